// File: rtl/grid_world_ram.sv
// grid_world_ram: cell grid with a read-before-write game port, a registered VGA read port,
// a sequential clear sweep and a live count of cells that differ from CLR_VAL.
module grid_world_ram #(
    parameter int GRID_W  = 15,
    parameter int GRID_H  = 15,
    parameter int CELL_W  = 2,
    parameter int CLR_VAL = 0,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int N  = GRID_W * GRID_H,
    localparam int AW = $clog2(N),
    localparam int CW = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic [XW-1:0]     g_x,
    input  logic [YW-1:0]     g_y,
    input  logic              g_we,
    input  logic              g_re,
    input  logic [CELL_W-1:0] g_wdata,
    output logic [CELL_W-1:0] g_rdata,
    output logic              g_rvalid,
    output logic              g_err,
    input  logic [XW-1:0]     v_x,
    input  logic [YW-1:0]     v_y,
    output logic [CELL_W-1:0] v_rdata,
    output logic [CW-1:0]     occ_count
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [CELL_W-1:0] CV   = CELL_W'(CLR_VAL);
    localparam logic [XW:0]       GWL  = (XW + 1)'(GRID_W);
    localparam logic [YW:0]       GHL  = (YW + 1)'(GRID_H);
    localparam logic [AW-1:0]     LAST = AW'(N - 1);
    localparam logic [CW-1:0]     FULL = CW'(N);

    state_t            r_state;
    logic [AW-1:0]     r_cnt;
    logic [CELL_W-1:0] r_mem [N];
    logic              w_g_inr, w_v_inr, w_acc, w_ok, w_wr, w_inc, w_dec;
    logic [AW-1:0]     w_g_addr, w_v_addr;
    logic [CELL_W-1:0] w_old;

    assign clear_busy = r_state == CLEAR;
    assign w_g_inr    = ({1'b0, g_x} < GWL) && ({1'b0, g_y} < GHL);
    assign w_v_inr    = ({1'b0, v_x} < GWL) && ({1'b0, v_y} < GHL);
    assign w_g_addr   = AW'(g_y) * AW'(GRID_W) + AW'(g_x);
    assign w_v_addr   = AW'(v_y) * AW'(GRID_W) + AW'(v_x);
    assign w_acc      = g_we || g_re;
    // a pending clear outranks any game access in the same cycle
    assign w_ok       = !clear_busy && !clear_req && w_g_inr;
    assign w_wr       = w_ok && g_we;
    assign w_old      = r_mem[w_g_addr];
    assign w_inc      = w_wr && w_old == CV && g_wdata != CV && occ_count != FULL;
    assign w_dec      = w_wr && w_old != CV && g_wdata == CV && occ_count != '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= CLEAR;
            r_cnt     <= '0;
            g_rdata   <= '0;
            g_rvalid  <= 1'b0;
            g_err     <= 1'b0;
            v_rdata   <= '0;
            occ_count <= '0;
        end else begin
            if (clear_req) begin
                r_state <= CLEAR;
                r_cnt   <= '0;
            end else if (r_state == CLEAR) begin
                r_state <= r_cnt == LAST ? IDLE : CLEAR;
                r_cnt   <= r_cnt == LAST ? '0 : r_cnt + 1'b1;
            end
            g_rvalid <= w_acc;
            g_err    <= w_acc && !w_ok;
            if (w_acc)
                g_rdata <= w_ok ? w_old : '0;
            v_rdata   <= (clear_busy || !w_v_inr) ? CV : r_mem[w_v_addr];
            occ_count <= (clear_req || clear_busy) ? '0 :
                         w_inc ? occ_count + 1'b1 :
                         w_dec ? occ_count - 1'b1 : occ_count;
        end
    end

    // storage is left unreset; the post-reset sweep initialises it
    always_ff @(posedge clk) begin
        if (clear_busy)
            r_mem[r_cnt] <= CV;
        else if (w_wr)
            r_mem[w_g_addr] <= g_wdata;
    end
endmodule

// File: tb/tb_grid_world_ram.sv
// tb_grid_world_ram: directed and random stimulus against an array-based model of the grid.
module tb_grid_world_ram;
    localparam int GW = 15;
    localparam int GH = 15;
    localparam int N  = GW * GH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_req = 1'b0;
    logic       g_we = 1'b0;
    logic       g_re = 1'b0;
    logic [3:0] g_x = '0;
    logic [3:0] g_y = '0;
    logic [3:0] v_x = '0;
    logic [3:0] v_y = '0;
    logic [1:0] g_wdata = '0;
    logic       clear_busy, g_rvalid, g_err;
    logic [1:0] g_rdata, v_rdata;
    logic [7:0] occ_count;

    int mem [N];
    int sweep_left;
    int n_cmp = 0;
    int n_bad = 0;

    grid_world_ram #(.GRID_W(GW), .GRID_H(GH), .CELL_W(2), .CLR_VAL(0)) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(clear_busy),
        .g_x(g_x), .g_y(g_y), .g_we(g_we), .g_re(g_re), .g_wdata(g_wdata),
        .g_rdata(g_rdata), .g_rvalid(g_rvalid), .g_err(g_err),
        .v_x(v_x), .v_y(v_y), .v_rdata(v_rdata), .occ_count(occ_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int occupied();
        int c = 0;
        foreach (mem[i]) if (mem[i] != 0) c++;
        return c;
    endfunction

    task automatic wipe_model(input int left);
        foreach (mem[i]) mem[i] = 0;
        sweep_left = left;
    endtask

    // one clock with the given inputs; the model predicts what the edge produces
    task automatic cyc(input bit clr, input bit we, input bit re, input int x, input int y,
                       input int wd, input int vx, input int vy);
        bit acc, ok;
        int exp_rd, exp_v, a;
        clear_req = clr; g_we = we; g_re = re;
        g_x = 4'(x); g_y = 4'(y); g_wdata = 2'(wd); v_x = 4'(vx); v_y = 4'(vy);
        acc = we || re;
        ok = sweep_left == 0 && !clr && x < GW && y < GH;
        a = y * GW + x;
        exp_rd = ok ? mem[a] : 0;
        exp_v = (sweep_left > 0 || vx >= GW || vy >= GH) ? 0 : mem[vy * GW + vx];
        @(posedge clk);
        #1;
        if (ok && we) mem[a] = wd;
        if (clr) wipe_model(N);
        else if (sweep_left > 0) sweep_left--;
        check("rvalid", g_rvalid, acc);
        check("err", g_err, acc && !ok);
        if (acc) check("rdata", g_rdata, exp_rd);
        check("vga", v_rdata, exp_v);
        check("busy", clear_busy, sweep_left > 0);
        check("occ", occ_count, occupied());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_busy", clear_busy, 1);
        check("rst_rvalid", g_rvalid, 0);
        check("rst_err", g_err, 0);
        check("rst_rdata", g_rdata, 0);
        check("rst_vga", v_rdata, 0);
        check("rst_occ", occ_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wipe_model(N);
    endtask

    initial begin
        int px, py;
        #2;
        do_reset();
        idle(N + 2);
        cyc(0, 0, 0, 0, 0, 0, 14, 14);
        idle(1);
        // back-to-back writes to one cell, then VGA readback
        cyc(0, 1, 0, 0, 0, 2, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // write, read, erase
        cyc(0, 1, 0, 3, 3, 2, 3, 3);
        cyc(0, 0, 1, 3, 3, 0, 3, 3);
        cyc(0, 1, 1, 3, 3, 0, 3, 3);
        cyc(0, 0, 1, 3, 3, 0, 3, 3);
        // out-of-range accesses
        cyc(0, 1, 0, 15, 0, 3, 15, 0);
        cyc(0, 1, 0, 0, 15, 3, 0, 15);
        cyc(0, 0, 1, 15, 15, 0, 15, 15);
        // fill, then sweep with writes attempted throughout
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, i, i % 4 + 5, i % 3 + 1, i, 5);
        cyc(1, 1, 0, 1, 1, 2, 1, 1);
        for (int i = 0; i < N; i++) cyc(0, 1, 0, i % GW, (i / GW) % GH, 3, i % GW, 0);
        idle(1);
        for (int i = 0; i < N; i++) cyc(0, 0, 1, i % GW, i / GW, 0, i % GW, i / GW);
        // reset mid-sweep
        cyc(0, 1, 0, 7, 7, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(100);
        do_reset();
        idle(N + 2);
        // randomised traffic with occasional same-cell repeats and rare clears
        px = 0; py = 0;
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 3);
            if (r != 0) begin
                px = (r == 1) ? $urandom_range(0, 15) : $urandom_range(0, 5);
                py = (r == 1) ? $urandom_range(0, 15) : $urandom_range(0, 5);
            end
            cyc($urandom_range(0, 399) == 0, $urandom_range(0, 1), $urandom_range(0, 1), px, py,
                $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
        end
        idle(N + 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 2, 2, 1, 2, 2);
        idle(N + 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
